quad_decoder: RTL and testbench

Quadrature decoder that turns two-phase A/B signals into registered up/down count steps, driving the same up/down counting convention as the team's synchronous up/down counter (direction 0 = up, 1 = down). It sits at the boundary between an asynchronous encoder or pulse source and the counting datapath. It synchronises and de-glitches both phases, decodes Gray-sequence transitions into signed steps, and maintains a wrap-around position count with illegal-transition flagging.

---
 rtl/quad_pkg.sv | 24 ++
 rtl/quad_filter.sv | 50 +++++
 rtl/quad_decoder.sv | 104 ++++++++++
 tb/tb_quad_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: direction codes, Gray phase
// encodings and the forward-successor helper.
package quad_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_e;

  function automatic phase_e quad_next(input phase_e prev);
    case (prev)
      PH_00:   quad_next = PH_01;
      PH_01:   quad_next = PH_11;
      PH_11:   quad_next = PH_10;
      default: quad_next = PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Single-phase input conditioning: SYNC_STAGES-flop synchroniser followed by
// a filter that accepts a new level only after it has held FILTER cycles.
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = $clog2(FILTER + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised level agrees with the filter output
  // restarts the count, so short pulses never get through.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_out != filt_q) begin
      if (cnt_q + CW'(1) == CW'(FILTER)) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_o = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: conditions A/B, decodes Gray transitions into up/down
// steps and keeps a wrap-around position count with illegal-jump flagging.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             err_sticky
);

  logic             fa, fb;
  phase_e           cur;
  phase_e           phase_q, phase_d;
  logic             primed_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_filt_a (
    .clk (clk),
    .rst (rst),
    .d_i (a),
    .q_o (fa)
  );

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_filt_b (
    .clk (clk),
    .rst (rst),
    .d_i (b),
    .q_o (fb)
  );

  assign cur = phase_e'({fa, fb});

  // Phase state follows the filtered inputs unconditionally; only the count
  // and its flags are gated by primed/en, so disabled transitions are lost.
  always_comb begin
    phase_d  = cur;
    count_d  = count_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    if (primed_q && en && (cur != phase_q)) begin
      if (quad_next(phase_q) == cur) begin
        count_d = count_q + WIDTH'(1);
        dir_d   = DIR_UP;
        step_d  = 1'b1;
      end else if (quad_next(cur) == phase_q) begin
        count_d = count_q - WIDTH'(1);
        dir_d   = DIR_DOWN;
        step_d  = 1'b1;
      end else begin
        err_d    = 1'b1;
        sticky_d = 1'b1;
      end
    end
    if (clr) begin
      count_d  = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_00;
      primed_q <= 1'b0;
      count_q  <= '0;
      dir_q    <= DIR_UP;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      primed_q <= 1'b1;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign count      = count_q;
  assign dir        = dir_q;
  assign step       = step_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder with a position/phase reference model
// kept as plain integers (Gray table index and modulo-16 count).
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst, a, b, en, clr;
  logic [3:0] count;
  logic       dir, step, err, err_sticky;

  int checks   = 0;
  int failures = 0;
  int step_seen = 0;
  int err_seen  = 0;

  int m_count = 0;
  int m_idx   = 0;
  int seq [4] = '{0, 1, 3, 2};

  quad_decoder #(.WIDTH(4), .SYNC_STAGES(2), .FILTER(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .en         (en),
    .clr        (clr),
    .count      (count),
    .dir        (dir),
    .step       (step),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) step_seen++;
    if (err === 1'b1) err_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_phase();
    int v;
    v = seq[m_idx];
    a = v[1];
    b = v[0];
  endtask

  task automatic move(input bit fwd, input int hold);
    m_idx = fwd ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
    drive_phase();
    tick(hold);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1; clr = 1'b0;
    m_idx = 0; m_count = 0;
    tick(3);
    rst = 1'b0;
    tick(6);
    chk("reset_count", int'(count), 0);
    chk("reset_step", int'(step), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_sticky", int'(err_sticky), 0);
  endtask

  task automatic test_forward();
    int s0, dir_bad;
    s0 = step_seen;
    dir_bad = 0;
    for (int i = 0; i < 20; i++) begin
      move(1'b1, 8);
      m_count = (m_count + 1) % 16;
      chk("fwd_count", int'(count), m_count);
      if (dir !== 1'b0) dir_bad++;
    end
    chk("fwd_final_count", int'(count), 4);
    chk("fwd_steps", step_seen - s0, 20);
    chk("fwd_dir_up", dir_bad, 0);
  endtask

  task automatic test_reverse();
    clr = 1'b1; tick(1); clr = 1'b0;
    m_count = 0;
    chk("rev_pre_clr", int'(count), 0);
    m_idx = (m_idx + 3) % 4;
    drive_phase();
    tick(4);
    chk("rev_early_count", int'(count), 0);
    tick(1);
    m_count = 15;
    chk("rev_count", int'(count), 15);
    chk("rev_dir", int'(dir), 1);
    tick(3);
  endtask

  task automatic test_glitch();
    int s0;
    s0 = step_seen;
    a = ~a; tick(1); a = ~a;
    tick(8);
    chk("glitch_steps", step_seen - s0, 0);
    chk("glitch_count", int'(count), m_count);
  endtask

  task automatic test_error_clr();
    int e0;
    e0 = err_seen;
    m_idx = (m_idx + 2) % 4;
    drive_phase();
    tick(8);
    chk("err_pulses", err_seen - e0, 1);
    chk("err_sticky_set", int'(err_sticky), 1);
    chk("err_count", int'(count), m_count);
    chk("err_dir_kept", int'(dir), 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    m_count = 0;
    chk("clr_sticky", int'(err_sticky), 0);
    chk("clr_count", int'(count), 0);
  endtask

  task automatic test_clr_step();
    m_idx = (m_idx + 1) % 4;
    drive_phase();
    tick(4);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clrstep_count", int'(count), 0);
    chk("clrstep_step", int'(step), 1);
    chk("clrstep_dir", int'(dir), 0);
    tick(4);
    m_count = 0;
  endtask

  task automatic test_enable();
    int s0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) move(1'b1, 8);
    en = 1'b1;
    tick(2);
    chk("en_hold_count", int'(count), m_count);
    s0 = step_seen;
    move(1'b1, 8);
    m_count = (m_count + 1) % 16;
    chk("en_resume_count", int'(count), m_count);
    chk("en_resume_steps", step_seen - s0, 1);
    chk("en_resume_dir", int'(dir), 0);
  endtask

  task automatic test_random();
    bit fwd;
    int s0;
    s0 = step_seen;
    for (int i = 0; i < 40; i++) begin
      fwd = bit'($urandom_range(0, 1));
      move(fwd, int'($urandom_range(5, 10)));
      m_count = fwd ? (m_count + 1) % 16 : (m_count + 15) % 16;
      chk("rand_count", int'(count), m_count);
      chk("rand_dir", int'(dir), fwd ? 0 : 1);
    end
    chk("rand_steps", step_seen - s0, 40);
  endtask

  task automatic test_mid_reset();
    if (m_count == 0) begin
      move(1'b1, 8);
      m_count = 1;
    end
    chk("midrst_pre_count", int'(count), m_count);
    m_idx = 0;
    drive_phase();
    rst = 1'b1;
    tick(1);
    chk("midrst_count", int'(count), 0);
    chk("midrst_step", int'(step), 0);
    chk("midrst_sticky", int'(err_sticky), 0);
    rst = 1'b0;
    tick(8);
    m_count = 0;
    chk("midrst_reprime_count", int'(count), 0);
    move(1'b1, 8);
    m_count = 1;
    chk("midrst_after_step", int'(count), 1);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_error_clr();
    test_clr_step();
    test_enable();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
